display_driver: RTL and testbench

DISPLAY_DRIVER -- requirements
Module: display_driver

---
 rtl/display_driver_if.sv | 19 +
 rtl/display_driver.sv | 199 +++++++++++++++++++
 tb/tb_display_driver.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/display_driver_if.sv
// Signal bundle between the game logic and the seven-segment display driver.
interface display_driver_if;
  logic [1:0]  select;
  logic [1:0]  mode;
  logic [13:0] number;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;

  modport master (
    output select, mode, number,
    input  seg, an, dp
  );

  modport slave (
    input  select, mode, number,
    output seg, an, dp
  );
endinterface

// File: rtl/display_driver.sv
// Four-digit multiplexed seven-segment driver: a free-running double-dabble
// engine turns the reaction count into BCD, a refresh counter scans the digits,
// and a blink phase gates the display while the game shows its result.
module display_driver #(
  parameter int REFRESH_TICKS = 100000,
  parameter int BLINK_TICKS   = 25000000
) (
  input  logic clk,
  input  logic rst,
  display_driver_if.slave bus
);

  localparam int REFRESH_W = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;
  localparam int BLINK_W   = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [REFRESH_W-1:0] REFRESH_LAST = REFRESH_W'(REFRESH_TICKS - 1);
  localparam logic [BLINK_W-1:0]   BLINK_LAST   = BLINK_W'(BLINK_TICKS - 1);

  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    LOAD,
    SHIFT,
    COMMIT
  } conv_state_t;

  conv_state_t state, state_next;

  logic [13:0]          clamped;
  logic [29:0]          work;
  logic [3:0]           shift_cnt;
  logic [15:0]          bcd_reg;
  logic [REFRESH_W-1:0] refresh_cnt;
  logic [1:0]           index;
  logic [BLINK_W-1:0]   blink_cnt;
  logic                 blink_on;
  logic [6:0]           seg_q, seg_next;
  logic [3:0]           an_q, an_next;
  logic [3:0]           digit;
  logic [3:0]           lit_an;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

  // One shift-add-3 step: correct every BCD nibble that would overflow, then shift.
  function automatic logic [29:0] dabble_step(input logic [29:0] w);
    logic [29:0] t;
    t = w;
    for (int i = 0; i < 4; i++) begin
      if (t[14 + 4*i +: 4] >= 4'd5) begin
        t[14 + 4*i +: 4] = t[14 + 4*i +: 4] + 4'd3;
      end
    end
    return {t[28:0], 1'b0};
  endfunction

  assign clamped = (bus.number > 14'd9999) ? 14'd9999 : bus.number;

  // Conversion engine state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Conversion engine sequencing: load, fourteen shifts, commit, repeat forever.
  always_comb begin
    state_next = state;
    case (state)
      LOAD:    state_next = SHIFT;
      SHIFT:   if (shift_cnt == 4'd13) state_next = COMMIT;
      COMMIT:  state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  // Conversion datapath; the visible BCD register changes only on commit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      work      <= '0;
      shift_cnt <= '0;
      bcd_reg   <= '0;
    end else begin
      case (state)
        LOAD: begin
          work      <= {16'd0, clamped};
          shift_cnt <= '0;
        end
        SHIFT: begin
          work      <= dabble_step(work);
          shift_cnt <= shift_cnt + 4'd1;
        end
        COMMIT: begin
          bcd_reg <= work[29:14];
        end
        default: begin
          shift_cnt <= '0;
        end
      endcase
    end
  end

  // Digit scan: hold each digit for REFRESH_TICKS cycles, then move one place left.
  always_ff @(posedge clk) begin
    if (!rst) begin
      refresh_cnt <= '0;
      index       <= '0;
    end else if (refresh_cnt == REFRESH_LAST) begin
      refresh_cnt <= '0;
      index       <= index + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // Blink phase runs only in the result phase and restarts lit whenever it is left.
  always_ff @(posedge clk) begin
    if (!rst) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (bus.select != 2'd2) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign digit  = bcd_reg[{index, 2'b00} +: 4];
  assign lit_an = ~(4'b0001 << index);

  // Pick anode and cathode pattern for the current digit and game phase.
  always_comb begin
    seg_next = SEG_BLANK;
    an_next  = 4'hF;
    case (bus.select)
      2'd0: begin
        an_next = lit_an;
        case (index)
          2'd3:    seg_next = SEG_L;
          2'd2:    seg_next = SEG_DASH;
          2'd1:    seg_next = SEG_BLANK;
          default: seg_next = glyph({2'b00, bus.mode});
        endcase
      end
      2'd1: begin
        an_next  = lit_an;
        seg_next = glyph(digit);
      end
      2'd2: begin
        if (blink_on) begin
          an_next  = lit_an;
          seg_next = glyph(digit);
        end
      end
      default: begin
        an_next  = 4'hF;
        seg_next = SEG_BLANK;
      end
    endcase
  end

  // Anode and cathode registers update together so they never disagree.
  always_ff @(posedge clk) begin
    if (!rst) begin
      seg_q <= SEG_BLANK;
      an_q  <= 4'hF;
    end else begin
      seg_q <= seg_next;
      an_q  <= an_next;
    end
  end

  assign bus.seg = seg_q;
  assign bus.an  = an_q;
  assign bus.dp  = 1'b1;

endmodule

// File: tb/tb_display_driver.sv
// Directed self-checking bench for display_driver with short refresh and blink periods.
module tb_display_driver;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   k = 0;

  display_driver_if bus();

  display_driver #(
    .REFRESH_TICKS(4),
    .BLINK_TICKS(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  localparam logic [6:0] GLYPH [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [3:0] AN_OF [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time bound so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] sel, input logic [1:0] md, input logic [13:0] num);
    bus.select = sel;
    bus.mode   = md;
    bus.number = num;
  endtask

  // Advance n clock edges, ending on the falling edge where outputs are sampled.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end
  endtask

  // Index shown after the k-th edge since reset release (four edges per digit).
  function automatic int curIndex();
    return ((k - 1) / 4) % 4;
  endfunction

  // Check one full 16-cycle scan against the four expected digit patterns.
  task automatic checkScan(input string tag, input logic [6:0] s3, input logic [6:0] s2,
                           input logic [6:0] s1, input logic [6:0] s0);
    logic [6:0] exp_seg [4];
    int idx;
    exp_seg[0] = s0;
    exp_seg[1] = s1;
    exp_seg[2] = s2;
    exp_seg[3] = s3;
    for (int j = 0; j < 16; j++) begin
      idx = curIndex();
      checkOutput({tag, " an"}, 32'(bus.an), 32'(AN_OF[idx]));
      checkOutput({tag, " seg"}, 32'(bus.seg), 32'(exp_seg[idx]));
      tick(1);
    end
  endtask

  initial begin
    int idx;
    int bad;
    int seen5;
    int seen7;
    logic [6:0] blink_seg [4];
    logic [6:0] menu_seg [4];

    rst = 1'b0;
    applyStimulus(2'd0, 2'd1, 14'd0);
    tick(3);
    checkOutput("reset seg", 32'(bus.seg), 32'h7F);
    checkOutput("reset an", 32'(bus.an), 32'hF);
    checkOutput("reset dp", 32'(bus.dp), 32'h1);

    // Menu scan right after release.
    rst = 1'b1;
    k = 0;
    tick(1);
    checkOutput("menu d0 an", 32'(bus.an), 32'(4'b1110));
    checkOutput("menu d0 seg", 32'(bus.seg), 32'(7'b1111001));
    tick(4);
    checkOutput("menu d1 an", 32'(bus.an), 32'(4'b1101));
    checkOutput("menu d1 seg", 32'(bus.seg), 32'(7'b1111111));
    tick(4);
    checkOutput("menu d2 an", 32'(bus.an), 32'(4'b1011));
    checkOutput("menu d2 seg", 32'(bus.seg), 32'(7'b0111111));
    tick(4);
    checkOutput("menu d3 an", 32'(bus.an), 32'(4'b0111));
    checkOutput("menu d3 seg", 32'(bus.seg), 32'(7'b1000111));
    tick(4);
    checkOutput("menu wrap an", 32'(bus.an), 32'(4'b1110));
    checkOutput("dp idle", 32'(bus.dp), 32'h1);

    applyStimulus(2'd0, 2'd3, 14'd0);
    tick(1);
    checkScan("menu mode3", SEG_L, SEG_DASH, SEG_BLANK, GLYPH[3]);

    // Counting phase conversions.
    applyStimulus(2'd1, 2'd0, 14'd1234);
    tick(32);
    checkScan("count 1234", GLYPH[1], GLYPH[2], GLYPH[3], GLYPH[4]);
    applyStimulus(2'd1, 2'd0, 14'd16383);
    tick(32);
    checkScan("count 16383", GLYPH[9], GLYPH[9], GLYPH[9], GLYPH[9]);
    applyStimulus(2'd1, 2'd0, 14'd10000);
    tick(32);
    checkScan("count 10000", GLYPH[9], GLYPH[9], GLYPH[9], GLYPH[9]);
    applyStimulus(2'd1, 2'd0, 14'd0);
    tick(32);
    checkScan("count 0", GLYPH[0], GLYPH[0], GLYPH[0], GLYPH[0]);

    // Result phase blinking with 42 -> digits 0,0,4,2.
    applyStimulus(2'd1, 2'd0, 14'd42);
    tick(32);
    applyStimulus(2'd2, 2'd0, 14'd42);
    tick(1);
    blink_seg[0] = GLYPH[2];
    blink_seg[1] = GLYPH[4];
    blink_seg[2] = GLYPH[0];
    blink_seg[3] = GLYPH[0];
    for (int j = 0; j < 32; j++) begin
      idx = curIndex();
      if (((j / 8) % 2) == 0) begin
        checkOutput("blink lit an", 32'(bus.an), 32'(AN_OF[idx]));
        checkOutput("blink lit seg", 32'(bus.seg), 32'(blink_seg[idx]));
      end else begin
        checkOutput("blink dark an", 32'(bus.an), 32'hF);
      end
      tick(1);
    end
    tick(10);
    checkOutput("blink dark again an", 32'(bus.an), 32'hF);
    applyStimulus(2'd0, 2'd1, 14'd42);
    tick(1);
    menu_seg[0] = GLYPH[1];
    menu_seg[1] = SEG_BLANK;
    menu_seg[2] = SEG_DASH;
    menu_seg[3] = SEG_L;
    idx = curIndex();
    checkOutput("leave blink an", 32'(bus.an), 32'(AN_OF[idx]));
    checkOutput("leave blink seg", 32'(bus.seg), 32'(menu_seg[idx]));

    // Number toggling during conversions: only whole values may be committed.
    applyStimulus(2'd1, 2'd0, 14'd5);
    tick(32);
    bad = 0;
    seen5 = 0;
    seen7 = 0;
    for (int i = 0; i < 96; i++) begin
      if ((i % 3) == 0) bus.number = (bus.number == 14'd5) ? 14'd7 : 14'd5;
      tick(1);
      if (dut.bcd_reg == 16'h0005) seen5++;
      else if (dut.bcd_reg == 16'h0007) seen7++;
      else bad++;
    end
    checkOutput("toggle bad commits", 32'(bad), 32'd0);
    checkOutput("toggle saw 7", 32'(seen7 > 0), 32'd1);
    checkOutput("toggle saw 5", 32'(seen5 > 0), 32'd1);

    // Reset pulse while digit 2 is lit.
    applyStimulus(2'd1, 2'd0, 14'd1234);
    for (int i = 0; i < 16 && curIndex() != 2; i++) tick(1);
    checkOutput("pre-reset an", 32'(bus.an), 32'(4'b1011));
    rst = 1'b0;
    tick(1);
    checkOutput("mid reset seg", 32'(bus.seg), 32'h7F);
    checkOutput("mid reset an", 32'(bus.an), 32'hF);
    checkOutput("mid reset dp", 32'(bus.dp), 32'h1);
    rst = 1'b1;
    k = 0;
    tick(1);
    checkOutput("release an", 32'(bus.an), 32'(4'b1110));
    checkOutput("release seg", 32'(bus.seg), 32'(GLYPH[0]));
    bus.number = 14'd77;
    tick(14);
    checkOutput("no early commit", 32'(dut.bcd_reg), 32'h0);
    tick(1);
    checkOutput("first commit", 32'(dut.bcd_reg), 32'h1234);
    tick(16);
    checkOutput("second commit", 32'(dut.bcd_reg), 32'h0077);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
